// File: rtl/fifo_reader.sv
// fifo_reader: read-side master for the synchronous FIFO.
// Issues pops under a credit rule, captures the registered pop response and
// re-presents the words on a valid/ready stream through a 2-entry skid buffer.
// Optional feature: define FIFO_READER_BACKOFF_EN to idle for BACKOFF_CYCLES
// after an empty pop response instead of re-polling immediately.
module fifo_reader #(
  parameter int DATA_WIDTH     = 4,
  parameter int BACKOFF_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_val,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [1:0]            occCount_q, occCount_d;
  logic                  headPtr_q, headPtr_d;
  logic                  tailPtr_q, tailPtr_d;
  logic                  inFlight_q;
  logic [DATA_WIDTH-1:0] skidMem_q [2];
  logic [DATA_WIDTH-1:0] outData_q, outData_d;
  logic                  popNow;
  logic                  captureNow;
  logic                  creditOk;
  logic                  runState;

  // The FIFO valid flag is stale between pops, so a response only counts
  // when a pop was actually issued on the previous edge.
  assign popNow     = out_valid & out_ready;
  assign captureNow = inFlight_q & fifo_rd_val;
  assign out_valid  = (occCount_q != 2'd0);
  assign out_data   = outData_q;

  // A pop may only issue if the word it returns is guaranteed a skid slot,
  // counting words held, the word already in flight, and this cycle's drain.
  assign creditOk   = ({1'b0, occCount_q} + {2'b00, inFlight_q})
                      < (3'd2 + {2'b00, popNow});
  assign fifo_rd_en = reset & runState & creditOk;

`ifdef FIFO_READER_BACKOFF_EN
  typedef enum logic {RUN, BACKOFF} state_e;

  state_e     state_q, state_d;
  logic [7:0] backoffCnt_q, backoffCnt_d;

  // State register and backoff counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      backoffCnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      backoffCnt_q <= backoffCnt_d;
    end
  end

  // Next state: an empty response in RUN starts a fresh backoff window.
  always_comb begin
    state_d      = state_q;
    backoffCnt_d = backoffCnt_q;
    case (state_q)
      RUN: begin
        if (inFlight_q && !fifo_rd_val) begin
          state_d      = BACKOFF;
          backoffCnt_d = 8'(BACKOFF_CYCLES);
        end
      end
      BACKOFF: begin
        if (backoffCnt_q <= 8'd1) begin
          state_d      = RUN;
          backoffCnt_d = 8'd0;
        end else begin
          backoffCnt_d = backoffCnt_q - 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output decode: pops are only allowed while in RUN.
  always_comb begin
    runState = (state_q == RUN);
  end
`else
  assign runState = 1'b1;
`endif

  // Skid-buffer next state; out_data tracks whichever entry becomes head.
  always_comb begin
    occCount_d = occCount_q;
    headPtr_d  = headPtr_q ^ popNow;
    tailPtr_d  = tailPtr_q ^ captureNow;
    outData_d  = outData_q;
    case ({captureNow, popNow})
      2'b10:   occCount_d = occCount_q + 2'd1;
      2'b01:   occCount_d = occCount_q - 2'd1;
      default: occCount_d = occCount_q;
    endcase
    if (occCount_d != 2'd0) begin
      if (captureNow && (tailPtr_q == headPtr_d)) begin
        outData_d = fifo_rd_data;
      end else begin
        outData_d = skidMem_q[headPtr_d];
      end
    end
  end

  // Control registers; reset drops everything, including held words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      occCount_q <= 2'd0;
      headPtr_q  <= 1'b0;
      tailPtr_q  <= 1'b0;
      inFlight_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      occCount_q <= occCount_d;
      headPtr_q  <= headPtr_d;
      tailPtr_q  <= tailPtr_d;
      inFlight_q <= fifo_rd_en;
      outData_q  <= outData_d;
    end
  end

  // Skid storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (reset && captureNow) begin
      skidMem_q[tailPtr_q] <= fifo_rd_data;
    end
  end

  // Simulation-only sanity checks on the credit rule and parameter range.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(captureNow && !popNow && (occCount_q == 2'd2)))
        else $error("fifo_reader: skid buffer overflow");
    end
    assert ((BACKOFF_CYCLES >= 1) && (BACKOFF_CYCLES <= 255))
      else $error("fifo_reader: BACKOFF_CYCLES out of range");
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: table-driven bench for fifo_reader with a behavioural
// FIFO model that answers each issued pop one cycle later and otherwise
// holds its last (stale) response.
module tb_fifo_reader;

  localparam int DW = 4;
`ifdef FIFO_READER_BACKOFF_EN
  localparam bit BoOn = 1'b1;
`else
  localparam bit BoOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_val;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] accepted[$];
  logic          rdEnSeen;

  typedef struct {
    logic        rst;
    logic        rdy;
    int          nPush;
    logic [15:0] push;
    int          expRdEn;
    int          expValid;
    int          expData;
  } vec_t;

  vec_t vecs[$];

  fifo_reader #(.DATA_WIDTH(DW), .BACKOFF_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_val  (fifo_rd_val),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic int bo(input int withBo, input int withoutBo);
    return BoOn ? withBo : withoutBo;
  endfunction

  function automatic void addRow(input logic rst, input logic rdy, input int nPush,
                                 input logic [15:0] push, input int expRdEn,
                                 input int expValid, input int expData);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.nPush = nPush; v.push = push;
    v.expRdEn = expRdEn; v.expValid = expValid; v.expData = expData;
    vecs.push_back(v);
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic rdyV, input int nPush,
                               input logic [15:0] push);
    reset     = rstV;
    out_ready = rdyV;
    for (int i = 0; i < nPush; i++) fifoQ.push_back(push[15-4*i -: 4]);
  endtask

  task automatic checkOutput(input string tag, input int expRdEn, input int expValid,
                             input int expData);
    if (expRdEn >= 0)  compareVal({tag, ".rd_en"}, 32'(fifo_rd_en), 32'(expRdEn));
    if (expValid >= 0) compareVal({tag, ".valid"}, 32'(out_valid), 32'(expValid));
    if (expData >= 0)  compareVal({tag, ".data"}, 32'(out_data), 32'(expData));
  endtask

  // One clock: drive, sample mid-cycle, then let the FIFO model answer.
  task automatic stepCycle(input logic rstV, input logic rdyV, input int nPush,
                           input logic [15:0] push, input string tag,
                           input int expRdEn, input int expValid, input int expData);
    applyStimulus(rstV, rdyV, nPush, push);
    @(negedge clk);
    rdEnSeen = fifo_rd_en;
    if (out_valid === 1'b1 && out_ready === 1'b1) accepted.push_back(out_data);
    checkOutput(tag, expRdEn, expValid, expData);
    @(posedge clk);
    #1;
    if (rdEnSeen === 1'b1) begin
      if (fifoQ.size() > 0) begin
        fifo_rd_data = fifoQ.pop_front();
        fifo_rd_val  = 1'b1;
      end else begin
        fifo_rd_val  = 1'b0;
      end
    end
  endtask

  // Main test sequence.
  initial begin
    fifo_rd_data = '0;
    fifo_rd_val  = 1'b0;
    reset        = 1'b0;
    out_ready    = 1'b0;
    rdEnSeen     = 1'b0;

    // Reset held with FIFO holding 7,6,5.
    addRow(0, 1, 3, 16'h7650, 0, 0, 0);
    addRow(0, 1, 0, 16'h0000, 0, 0, 0);
    // Streaming 7,6,5 with consumer ready, then empty response.
    addRow(1, 1, 0, 16'h0000, 1, 0, 0);
    addRow(1, 1, 0, 16'h0000, 1, 0, 0);
    addRow(1, 1, 0, 16'h0000, 1, 1, 7);
    addRow(1, 1, 0, 16'h0000, 1, 1, 6);
    addRow(1, 1, 0, 16'h0000, 1, 1, 5);
    addRow(1, 1, 0, 16'h0000, bo(0, 1), 0, 5);
    addRow(1, 1, 0, 16'h0000, bo(0, 1), 0, 5);
    addRow(1, 1, 0, 16'h0000, bo(0, 1), 0, 5);
    addRow(1, 1, 0, 16'h0000, bo(0, 1), 0, 5);
    addRow(1, 1, 0, 16'h0000, 1, 0, 5);
    // Backpressure: 7,6,5,4 with out_ready low for 6 cycles.
    addRow(0, 0, 4, 16'h7654, 0, 0, 5);
    addRow(1, 0, 0, 16'h0000, 1, 0, 0);
    addRow(1, 0, 0, 16'h0000, 1, 0, 0);
    addRow(1, 0, 0, 16'h0000, 0, 1, 7);
    addRow(1, 0, 0, 16'h0000, 0, 1, 7);
    addRow(1, 0, 0, 16'h0000, 0, 1, 7);
    addRow(1, 0, 0, 16'h0000, 0, 1, 7);
    addRow(1, 1, 0, 16'h0000, 1, 1, 7);
    addRow(1, 1, 0, 16'h0000, 1, 1, 6);
    addRow(1, 1, 0, 16'h0000, 1, 1, 5);
    addRow(1, 1, 0, 16'h0000, 1, 1, 4);
    addRow(1, 1, 0, 16'h0000, bo(0, 1), 0, 4);
    // Mid-operation reset while holding 6, stale response afterwards.
    addRow(0, 0, 3, 16'h7650, 0, 0, 4);
    addRow(1, 0, 0, 16'h0000, 1, 0, 0);
    addRow(1, 0, 0, 16'h0000, 1, 0, 0);
    addRow(1, 0, 0, 16'h0000, 0, 1, 7);
    addRow(1, 1, 0, 16'h0000, 1, 1, 7);
    addRow(0, 0, 0, 16'h0000, 0, 1, 6);
    addRow(0, 0, 0, 16'h0000, 0, 0, 0);
    addRow(1, 1, 0, 16'h0000, 1, 0, 0);
    addRow(1, 1, 0, 16'h0000, 1, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      stepCycle(vecs[i].rst, vecs[i].rdy, vecs[i].nPush, vecs[i].push,
                $sformatf("row%0d", i), vecs[i].expRdEn, vecs[i].expValid,
                vecs[i].expData);
    end

    // Toggling consumer with FIFO holding 3,2,1: order and count preserved.
    accepted.delete();
    stepCycle(0, 0, 3, 16'h3210, "togRst", 0, -1, -1);
    for (int k = 0; k < 16; k++) begin
      stepCycle(1, (k % 2 == 0), 0, 16'h0000, $sformatf("tog%0d", k), -1, -1, -1);
    end
    compareVal("tog.count", 32'(accepted.size()), 32'd3);
    if (accepted.size() == 3) begin
      compareVal("tog.word0", 32'(accepted[0]), 32'd3);
      compareVal("tog.word1", 32'(accepted[1]), 32'd2);
      compareVal("tog.word2", 32'(accepted[2]), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
